// File: rtl/lsu_mem_unit_if.sv
// Memory-controller channel between the per-thread LSU and memory.
// Carries an independent read channel (valid/address out, ready/data back)
// and write channel (valid/address/data out, ready back).
// Modports: master = LSU side, slave = memory-controller side.
interface lsu_mem_unit_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_mem_unit.sv
// Per-thread load/store unit: one FSM drives either the read channel (LDR)
// or the write channel (STR) of the memory controller and returns loaded
// data to the register-file writeback mux via lsu_out.
// Ports:
//   clk, reset (sync, active-high), enable (low freezes all state)
//   core_state, decoded_mem_read_enable, decoded_mem_write_enable
//   rs (address operand), rt (store data)
//   mem (lsu_mem_unit_if.master): read/write request channels
//   lsu_state (IDLE=00 REQUESTING=01 WAITING=10 DONE=11), lsu_out, lsu_error
// Optional feature: define LSU_TIMEOUT_EN to abort WAITING after
// TIMEOUT_CYCLES cycles without ready (sets lsu_error); otherwise the unit
// waits forever and lsu_error is tied to 0.
module lsu_mem_unit #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter logic [2:0]  REQUEST_STATE  = 3'b011,
    parameter logic [2:0]  UPDATE_STATE   = 3'b110,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    lsu_mem_unit_if.master       mem,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_REQUESTING = 2'b01,
        ST_WAITING    = 2'b10,
        ST_DONE       = 2'b11
    } state_t;

    // A zero timeout would abort before any memory response could arrive.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_mem_unit: TIMEOUT_CYCLES must be >= 1");
    end

    state_t               state_q, state_d;
    logic                 is_load_q, is_load_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] out_q, out_d;

    logic                 op_c;
    logic                 ready_c;
    logic [ADDR_BITS-1:0] addr_c;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_BITS =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    assign op_c    = decoded_mem_read_enable | decoded_mem_write_enable;
    // Only the channel of the latched op can complete it.
    assign ready_c = is_load_q ? mem.mem_read_ready : mem.mem_write_ready;
    // Truncates or zero-extends rs to the address width.
    assign addr_c  = ADDR_BITS'(rs);

    // State and datapath registers; enable low holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_load_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else if (enable) begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_q      <= out_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        out_d      = out_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (op_c && (core_state == REQUEST_STATE)) begin
                    // Read wins when both enables are decoded.
                    is_load_d = decoded_mem_read_enable;
`ifdef LSU_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = ST_REQUESTING;
                end
            end

            ST_REQUESTING: begin
                if (is_load_q) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = addr_c;
                end else begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = addr_c;
                    wr_data_d  = rt;
                end
`ifdef LSU_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAITING;
            end

            ST_WAITING: begin
                if (ready_c) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    if (is_load_q) begin
                        out_d = mem.mem_read_data;
                    end
                    state_d = ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
`endif
            end

            ST_DONE: begin
                if (core_state == UPDATE_STATE) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_read_valid    = rd_valid_q;
    assign mem.mem_read_address  = rd_addr_q;
    assign mem.mem_write_valid   = wr_valid_q;
    assign mem.mem_write_address = wr_addr_q;
    assign mem.mem_write_data    = wr_data_q;
    assign lsu_state             = 2'(state_q);
    assign lsu_out               = out_q;
`ifdef LSU_TIMEOUT_EN
    assign lsu_error             = err_q;
`else
    assign lsu_error             = 1'b0;
`endif

endmodule
